// File: rtl/flow_input_scheduler_if.sv
// Handshake bundle between the pixel sources, the sequencer and the tagged
// accelerator input port of flow_input_scheduler.
interface flow_input_scheduler_if #(
   parameter int FLUX   = 4,
   parameter int DATA_W = 8,
   parameter int TAG_W  = 2,
   parameter int CNT_W  = 13
);
   logic                    cfg_valid;
   logic [TAG_W-1:0]        cfg_flow;
   logic [CNT_W-1:0]        cfg_count;
   logic                    cfg_ready;

   logic [FLUX-1:0]         src_valid;
   logic [FLUX*DATA_W-1:0]  src_data;
   logic [FLUX-1:0]         src_ready;

   logic [TAG_W+DATA_W-1:0] out_din;
   logic                    out_write;
   logic [FLUX-1:0]         out_full;

   logic [FLUX-1:0]         flow_active;
   logic [FLUX-1:0]         flow_done;

   modport master (
      output cfg_valid, cfg_flow, cfg_count,
      input  cfg_ready,
      output src_valid, src_data,
      input  src_ready,
      input  out_din, out_write,
      output out_full,
      input  flow_active, flow_done
   );

   modport slave (
      input  cfg_valid, cfg_flow, cfg_count,
      output cfg_ready,
      input  src_valid, src_data,
      output src_ready,
      output out_din, out_write,
      input  out_full,
      output flow_active, flow_done
   );
endinterface

// File: rtl/flow_input_scheduler.sv
// Round-robin scheduler sharing one tagged accelerator write port among FLUX
// budgeted pixel sources; reports per-flow activity and completion.
module flow_input_scheduler #(
   parameter int FLUX   = 4,
   parameter int DATA_W = 8,
   parameter int TAG_W  = 2,
   parameter int CNT_W  = 13
) (
   input logic                    clk,
   input logic                    rst,
   flow_input_scheduler_if.slave  bus
);

   typedef enum logic {
      FLOW_IDLE   = 1'b0,
      FLOW_ACTIVE = 1'b1
   } flow_state_e;

   flow_state_e      state_q     [FLUX];
   flow_state_e      state_d     [FLUX];
   logic [CNT_W-1:0] remaining_q [FLUX];
   logic [CNT_W-1:0] remaining_d [FLUX];
   logic [TAG_W-1:0] rr_ptr_q;
   logic [TAG_W-1:0] rr_ptr_d;
   logic [FLUX-1:0]  done_q;
   logic [FLUX-1:0]  done_d;

   logic [FLUX-1:0]  active;
   logic [FLUX-1:0]  elig;
   logic             grant_vld;
   logic [TAG_W-1:0] grant_idx;
   logic [TAG_W-1:0] scan_idx;
   logic             arm_fire;

   always_comb begin
      for (int i = 0; i < FLUX; i++) begin
         active[i] = (state_q[i] == FLOW_ACTIVE);
      end
   end

   assign elig     = active & bus.src_valid & ~bus.out_full;
   assign arm_fire = bus.cfg_valid && bus.cfg_ready;

   assign bus.cfg_ready   = !active[bus.cfg_flow];
   assign bus.flow_active = active;
   assign bus.flow_done   = done_q;

   // Scan starts just after the last winner; TAG_W truncation gives the wrap
   // because FLUX is a power of two. No grants are issued while in reset.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 1; k <= FLUX; k++) begin
         scan_idx = TAG_W'(int'(rr_ptr_q) + k);
         if (!grant_vld && rst && elig[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      bus.src_ready = '0;
      bus.out_write = grant_vld;
      bus.out_din   = '0;
      if (grant_vld) begin
         bus.src_ready[grant_idx] = 1'b1;
         bus.out_din = {grant_idx, bus.src_data[int'(grant_idx)*DATA_W +: DATA_W]};
      end
   end

   // Next-state for all flows. An arm and a grant never target the same flow:
   // arming needs the flow idle, granting needs it active.
   always_comb begin
      // NOTE: combinational next-state uses blocking '=' so later lines see earlier updates.
      state_d     = state_q;
      remaining_d = remaining_q;
      rr_ptr_d    = rr_ptr_q;
      done_d      = '0;

      if (grant_vld) begin
         rr_ptr_d               = grant_idx;
         remaining_d[grant_idx] = remaining_q[grant_idx] - CNT_W'(1);
         if (remaining_q[grant_idx] == CNT_W'(1)) begin
            state_d[grant_idx] = FLOW_IDLE;
            done_d[grant_idx]  = 1'b1;
         end
      end

      if (arm_fire) begin
         if (bus.cfg_count != '0) begin
            state_d[bus.cfg_flow]     = FLOW_ACTIVE;
            remaining_d[bus.cfg_flow] = bus.cfg_count;
         end else begin
            done_d[bus.cfg_flow] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the budget array is cleared too, so a reset mid-transfer leaves no stale count behind.
         for (int i = 0; i < FLUX; i++) begin
            state_q[i]     <= FLOW_IDLE;
            remaining_q[i] <= '0;
         end
         rr_ptr_q <= TAG_W'(FLUX - 1);
         done_q   <= '0;
      end else begin
         // NOTE: registered state uses non-blocking '<=' so all flops update together.
         for (int i = 0; i < FLUX; i++) begin
            state_q[i]     <= state_d[i];
            remaining_q[i] <= remaining_d[i];
         end
         rr_ptr_q <= rr_ptr_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_flow_input_scheduler.sv
// Directed self-checking bench for flow_input_scheduler: reset, rotation,
// budgets, full back-pressure, same-cycle re-arm and mid-stream reset.
module tb_flow_input_scheduler;
   localparam int FLUX   = 4;
   localparam int DATA_W = 8;
   localparam int TAG_W  = 2;
   localparam int CNT_W  = 13;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   flow_input_scheduler_if #(.FLUX(FLUX), .DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   flow_input_scheduler #(.FLUX(FLUX), .DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DATA_W-1:0] data_of(input int f, input int c);
      return DATA_W'(c * 7 + f * 61 + 5);
   endfunction

   task automatic set_data(input int c);
      for (int f = 0; f < FLUX; f++) bus.src_data[f*DATA_W +: DATA_W] = data_of(f, c);
   endtask

   task automatic arm(input int f, input int n);
      bus.cfg_valid = 1'b1;
      bus.cfg_flow  = TAG_W'(f);
      bus.cfg_count = CNT_W'(n);
   endtask

   function automatic logic [TAG_W-1:0] tag_of(input logic [TAG_W+DATA_W-1:0] din);
      return din[TAG_W+DATA_W-1 -: TAG_W];
   endfunction

   int tag_cnt [FLUX];
   int nwrites;
   bit seen;
   int seq3 [3] = '{3, 0, 2};

   initial begin
      bus.cfg_valid = 1'b0;
      bus.cfg_flow  = '0;
      bus.cfg_count = '0;
      bus.src_valid = '1;
      bus.src_data  = '0;
      bus.out_full  = '0;

      // Reset hold with all sources valid
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("rst_out_write",   32'(bus.out_write),   0);
      check("rst_out_din",     32'(bus.out_din),     0);
      check("rst_flow_active", 32'(bus.flow_active), 0);
      check("rst_flow_done",   32'(bus.flow_done),   0);
      check("rst_src_ready",   32'(bus.src_ready),   0);
      check("rst_cfg_ready",   32'(bus.cfg_ready),   1);

      // Arm all four flows with budget 4, sources held off
      @(negedge clk); rst = 1'b1; bus.src_valid = '0; arm(0, 4);
      #1 check("arm0_ready", 32'(bus.cfg_ready), 1);
      @(negedge clk); arm(1, 4);
      #1 check("arm0_active", 32'(bus.flow_active), 32'b0001);
      @(negedge clk); arm(2, 4);
      @(negedge clk); arm(3, 4);
      #1 check("arm2_active", 32'(bus.flow_active), 32'b0111);

      for (int w = 0; w < 16; w++) begin
         @(negedge clk);
         if (w == 0) begin
            bus.cfg_valid = 1'b0;
            bus.src_valid = '1;
         end
         set_data(w);
         #1;
         check("rot_write",     32'(bus.out_write), 1);
         check("rot_din",       32'(bus.out_din), 32'({TAG_W'(w % 4), data_of(w % 4, w)}));
         check("rot_src_ready", 32'(bus.src_ready), 32'(1) << (w % 4));
         check("rot_done",      32'(bus.flow_done), (w >= 13) ? (32'(1) << (w - 13)) : 32'(0));
      end
      @(negedge clk); #1;
      check("rot_end_write",  32'(bus.out_write),   0);
      check("rot_end_done",   32'(bus.flow_done),   32'b1000);
      check("rot_end_active", 32'(bus.flow_active), 0);

      // Budgets 2,5,0,3 with flow 1 valid every other cycle
      @(negedge clk); bus.src_valid = '0; arm(0, 2);
      @(negedge clk); arm(1, 5);
      @(negedge clk); arm(2, 0);
      @(negedge clk); arm(3, 3);
      #1;
      check("zero_done",   32'(bus.flow_done),   32'b0100);
      check("zero_active", 32'(bus.flow_active), 32'b0011);
      for (int f = 0; f < FLUX; f++) tag_cnt[f] = 0;
      nwrites = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) bus.cfg_valid = 1'b0;
         bus.src_valid = (c % 2 == 0) ? 4'b1111 : 4'b1101;
         set_data(c);
         #1;
         if (bus.out_write) begin
            nwrites++;
            tag_cnt[tag_of(bus.out_din)]++;
         end
      end
      check("mix_total",  32'(nwrites),    10);
      check("mix_tag0",   32'(tag_cnt[0]), 2);
      check("mix_tag1",   32'(tag_cnt[1]), 5);
      check("mix_tag2",   32'(tag_cnt[2]), 0);
      check("mix_tag3",   32'(tag_cnt[3]), 3);
      check("mix_active", 32'(bus.flow_active), 0);

      // Flow 1 held full for 20 cycles; the last winner of the previous phase was flow 1
      @(negedge clk); bus.src_valid = '0; arm(0, 225);
      @(negedge clk); arm(1, 225);
      @(negedge clk); arm(2, 225);
      @(negedge clk); arm(3, 225);
      @(negedge clk); bus.cfg_valid = 1'b0; bus.src_valid = '1; set_data(100);
      #1 check("pre_full_tag", 32'(tag_of(bus.out_din)), 2);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.out_full = 4'b0010;
         set_data(101 + c);
         #1;
         check("full_write",     32'(bus.out_write), 1);
         check("full_tag",       32'(tag_of(bus.out_din)), 32'(seq3[c % 3]));
         check("full_no_ready1", 32'(bus.src_ready[1]), 0);
      end
      @(negedge clk); bus.out_full = '0; set_data(130);
      #1 check("release_din", 32'(bus.out_din), 32'({2'd1, data_of(1, 130)}));

      // Clear everything before the re-arm scenario
      @(negedge clk); rst = 1'b0; bus.src_valid = '0;
      @(negedge clk); rst = 1'b1;
      #1 check("clr_active", 32'(bus.flow_active), 0);

      // Re-arm flow 2 in the cycle its last sample is granted
      @(negedge clk); arm(2, 3); bus.src_valid = 4'b0100;
      #1 check("re_first_write", 32'(bus.out_write), 0);
      @(negedge clk); bus.cfg_valid = 1'b0;
      #1 check("re_g1", 32'(bus.out_write), 1);
      @(negedge clk);
      #1 check("re_g2", 32'(bus.out_write), 1);
      @(negedge clk); arm(2, 49);
      #1;
      check("re_last_write", 32'(bus.out_write), 1);
      check("re_blocked",    32'(bus.cfg_ready), 0);
      @(negedge clk);
      #1;
      check("re_accept",   32'(bus.cfg_ready), 1);
      check("re_gap",      32'(bus.out_write), 0);
      check("re_done",     32'(bus.flow_done), 32'b0100);
      nwrites = 0;
      for (int n = 0; n < 49; n++) begin
         @(negedge clk);
         if (n == 0) bus.cfg_valid = 1'b0;
         #1;
         if (bus.out_write && tag_of(bus.out_din) == 2'd2) nwrites++;
      end
      check("re_writes", 32'(nwrites), 49);
      @(negedge clk); #1;
      check("re_end_write",  32'(bus.out_write),   0);
      check("re_end_done",   32'(bus.flow_done),   32'b0100);
      check("re_end_active", 32'(bus.flow_active), 0);

      // Mid-stream reset after 37 of 5041 samples on flow 3
      @(negedge clk); arm(3, 5041); bus.src_valid = 4'b1000;
      #1 check("big_ready", 32'(bus.cfg_ready), 1);
      nwrites = 0;
      for (int n = 0; n < 37; n++) begin
         @(negedge clk);
         if (n == 0) bus.cfg_valid = 1'b0;
         #1;
         if (bus.out_write && tag_of(bus.out_din) == 2'd3) nwrites++;
      end
      check("big_pre_writes", 32'(nwrites), 37);
      @(negedge clk); rst = 1'b0;
      #1 check("big_rst_gate", 32'(bus.out_write), 0);
      @(negedge clk); rst = 1'b1;
      #1;
      check("big_post_write",  32'(bus.out_write),   0);
      check("big_post_active", 32'(bus.flow_active), 0);
      check("big_post_done",   32'(bus.flow_done),   0);
      @(negedge clk); arm(3, 5041);
      #1 check("big_rearm_ready", 32'(bus.cfg_ready), 1);
      nwrites = 0;
      seen = 1'b0;
      for (int c = 0; c < 6000 && !seen; c++) begin
         @(negedge clk);
         if (c == 0) bus.cfg_valid = 1'b0;
         #1;
         if (bus.flow_done[3]) seen = 1'b1;
         else if (bus.out_write) nwrites++;
      end
      check("big_done_seen", 32'(seen),    1);
      check("big_restart",   32'(nwrites), 5041);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/flow_input_scheduler.md
Name: flow_input_scheduler

Overview:
- Round-robin scheduler that shares the single tagged input write port of the multi-flow HEVC accelerator among FLUX independent pixel sources.
- Each flow is armed with a sample budget, normally (size+TAP-1)^2. The block then interleaves one word per grant into the tagged stream {flow_id, pel} and honours per-flow downstream full.
- Reports per-flow activity and completion to the top-level sequencer.

Parameters:
- FLUX, 4, number of flows/sources; power of two, 2..8.
- DATA_W, 8, pixel width.
- TAG_W, 2, flow tag width, = clog2(FLUX).
- CNT_W, 13, sample budget width; must hold 71*71 = 5041.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- cfg_valid  in  1  arm request.
- cfg_flow  in  TAG_W  flow to arm.
- cfg_count  in  CNT_W  samples to transfer.
- cfg_ready  out  1  arm accepted this cycle when high together with cfg_valid.
- src_valid  in  FLUX  per-flow sample available.
- src_data  in  FLUX*DATA_W  per-flow sample; flow i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  FLUX  per-flow sample consumed (one-hot or zero).
- out_din  out  TAG_W+DATA_W  tagged word {flow_id, pel} to the accelerator input FIFO.
- out_write  out  1  out_din valid.
- out_full  in  FLUX  per-flow full from the accelerator input FIFOs.
- flow_active  out  FLUX  flow armed with budget remaining.
- flow_done  out  FLUX  one-cycle pulse when a flow's last sample is granted.

Behaviour:
- Reset (rst=0 at an edge):
  - active[]=0, remaining[]=0, rr_ptr=FLUX-1 so flow 0 has first priority.
  - out_write=0, out_din=0, flow_done=0, src_ready=0.
  - Reset mid-transfer abandons all budgets; no done pulses are issued.
- Per-flow state is IDLE (active=0) or ACTIVE (active=1). flow_active mirrors active.
- Arming:
  - cfg_ready = !active[cfg_flow], combinational.
  - On cfg_valid && cfg_ready with cfg_count>0: active <= 1, remaining <= cfg_count.
  - cfg_count=0 is accepted but does not activate; flow_done[cfg_flow] pulses on the next cycle.
- Eligibility: elig[i] = active[i] && src_valid[i] && !out_full[i].
- Grant:
  - Combinational, at most one per cycle.
  - Winner is the first eligible flow scanning (rr_ptr+1) .. (rr_ptr+FLUX) mod FLUX.
- Output path (zero latency, combinational from grant):
  - With a winner g: src_ready[g]=1, out_write=1, out_din={g[TAG_W-1:0], src_data[g]}.
  - With no winner: out_write=0, out_din=0.
- Grant bookkeeping at the edge:
  - rr_ptr <= g; rr_ptr is unchanged on cycles with no grant.
  - remaining[g] <= remaining[g]-1.
  - If remaining[g]==1: active[g] <= 0 and flow_done[g] <= 1 for exactly one cycle.
- Fairness: with all flows eligible, grants rotate 0,1,2,3,0,...
  - A full or idle flow is skipped without losing its turn order.
  - Worst-case wait for an eligible flow is FLUX-1 cycles.
- Simultaneous events:
  - A flow granted its last sample keeps cfg_ready low for that flow in the same cycle; a re-arm is accepted the following cycle at the earliest.
  - An arm for flow A and a grant for flow B in the same cycle both take effect.
  - A newly armed flow is not eligible until the cycle after acceptance.
- out_full is sampled in the grant cycle. No write is ever issued to a flow whose full bit is high in that cycle.
- remaining never underflows; a grant requires active, which implies remaining>=1.

Test Plan:
- Reset hold 10 cycles with src_valid=all ones -> out_write=0, flow_active=0000, cfg_ready=1; first arm of flow 0 succeeds on release.
- Arm flows 0..3 with 4,4,4,4, all src_valid=1, out_full=0 -> 16 consecutive writes with tags 0,1,2,3 repeating; flow_done pulses 0001,0010,0100,1000 on cycles 13..16 relative to first write; all flow_active ends at 0.
- Budgets 2,5,0,3, flow 1 src_valid toggling 1/0 -> flow 2 done pulse one cycle after arm with no writes; total writes exactly 10; tag counts 2/5/0/3.
- Hold out_full[1]=1 for 20 cycles with all flows armed for 225 samples -> no tag-1 writes during that window; flows 0,2,3 alternate; tag 1 is granted on the first cycle after release.
- Re-arm flow 2 (cfg_count=49) in the cycle its last sample is granted -> cfg_ready=0 that cycle; accepted the next cycle; 49 further tag-2 writes follow.
- Assert rst low mid-stream after 37 of 5041 samples for flow 3 -> the next cycle shows out_write=0, flow_active=0, no flow_done pulse; re-arm restarts from 5041.
